// File: rtl/traffic_light_ctrl_n_if.sv
// Request/indication bundle between an intersection controller and its environment.
// The master side raises requests and watches lights; the slave side is the controller.
interface traffic_light_ctrl_n_if #(
  parameter int N_DIR = 2
);
  logic               emerg_req;
  logic [1:0]         emerg_dir;
  logic               ped_req;
  logic [2*N_DIR-1:0] light;
  logic               walk;
  logic               buzzer;
  logic [1:0]         cur_dir;
  logic               emerg_active;

  modport master (
    output emerg_req, emerg_dir, ped_req,
    input  light, walk, buzzer, cur_dir, emerg_active
  );

  modport slave (
    input  emerg_req, emerg_dir, ped_req,
    output light, walk, buzzer, cur_dir, emerg_active
  );
endinterface

// File: rtl/traffic_light_ctrl_n.sv
// Round-robin N-direction traffic light controller with pedestrian phase and emergency preemption.
// Optional feature macro: TLC_PED_REQ_EN (walk phase served only on a latched ped_req).
module traffic_light_ctrl_n #(
  parameter int N_DIR    = 2,
  parameter int T_GREEN  = 30,
  parameter int T_YELLOW = 5,
  parameter int T_ALLRED = 2,
  parameter int T_WALK   = 55,
  parameter int T_CLR    = 5,
  parameter int TW       = 7
) (
  input  logic                   clk,
  input  logic                   reset,
  traffic_light_ctrl_n_if.slave  bus
);

  typedef enum logic [2:0] {
    S_GREEN, S_YELLOW, S_ALLRED, S_WALK, S_WALK_CLR, S_EMERG
  } state_t;

  localparam logic [1:0] LT_GREEN  = 2'b00;
  localparam logic [1:0] LT_YELLOW = 2'b01;
  localparam logic [1:0] LT_RED    = 2'b10;

  localparam logic [TW-1:0] GREEN_LAST  = TW'(T_GREEN - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(T_YELLOW - 1);
  localparam logic [TW-1:0] ALLRED_LAST = TW'(T_ALLRED - 1);
  localparam logic [TW-1:0] WALK_LAST   = TW'(T_WALK - 1);
  localparam logic [TW-1:0] CLR_LAST    = TW'(T_CLR - 1);
  localparam logic [TW-1:0] TIMER_MAX   = '1;
  localparam logic [1:0]    LAST_DIR    = 2'(N_DIR - 1);
  localparam logic [2*N_DIR-1:0] LIGHT_RST = {{(N_DIR-1){LT_RED}}, LT_GREEN};

  state_t             state_reg, state_next;
  logic [1:0]         cur_dir_reg, cur_dir_next;
  logic [TW-1:0]      timer_reg, timer_next;
  logic [TW-1:0]      timer_last;
  logic               timer_done;
  logic               post_walk_reg, post_walk_next;
  logic               ped_pending;
  logic [1:0]         edir;
  logic [2*N_DIR-1:0] light_reg, light_next;
  logic               walk_reg, walk_next;
  logic               buzzer_reg, buzzer_next;
  logic               emerg_active_reg, emerg_active_next;

  // Out-of-range emergency directions fall back to direction 0.
  assign edir = (int'(bus.emerg_dir) < N_DIR) ? bus.emerg_dir : 2'd0;

`ifdef TLC_PED_REQ_EN
  logic ped_lat_reg, ped_lat_next;

  always_comb begin
    ped_lat_next = ped_lat_reg | bus.ped_req;
    if (state_next == S_WALK && state_reg != S_WALK)
      ped_lat_next = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) ped_lat_reg <= 1'b0;
    else       ped_lat_reg <= ped_lat_next;
  end

  assign ped_pending = ped_lat_reg;
`else
  logic unused_ped_req;
  assign unused_ped_req = bus.ped_req;
  assign ped_pending    = 1'b1;
`endif

  always_comb begin
    timer_last = TIMER_MAX;
    case (state_reg)
      S_GREEN:    timer_last = GREEN_LAST;
      S_YELLOW:   timer_last = YELLOW_LAST;
      S_ALLRED:   timer_last = ALLRED_LAST;
      S_WALK:     timer_last = WALK_LAST;
      S_WALK_CLR: timer_last = CLR_LAST;
      default:    timer_last = TIMER_MAX;
    endcase
  end

  assign timer_done = (timer_reg == timer_last);

  // Next-state logic.
  always_comb begin
    state_next     = state_reg;
    cur_dir_next   = cur_dir_reg;
    post_walk_next = post_walk_reg;
    case (state_reg)
      S_GREEN: begin
        if (bus.emerg_req)
          state_next = (cur_dir_reg == edir) ? S_EMERG : S_YELLOW;
        else if (timer_done)
          state_next = S_YELLOW;
      end
      S_YELLOW: begin
        if (timer_done) state_next = S_ALLRED;
      end
      S_ALLRED: begin
        if (timer_done) begin
          post_walk_next = 1'b0;
          if (bus.emerg_req) begin
            state_next   = S_EMERG;
            cur_dir_next = edir;
          end else if (post_walk_reg || (cur_dir_reg == LAST_DIR && !ped_pending)) begin
            state_next   = S_GREEN;
            cur_dir_next = 2'd0;
          end else if (cur_dir_reg == LAST_DIR) begin
            state_next   = S_WALK;
          end else begin
            state_next   = S_GREEN;
            cur_dir_next = cur_dir_reg + 2'd1;
          end
        end
      end
      S_WALK: begin
        if (bus.emerg_req || timer_done) state_next = S_WALK_CLR;
      end
      S_WALK_CLR: begin
        if (timer_done) begin
          if (bus.emerg_req) begin
            // Remember the walk was already served so a release during ALLRED resumes at GREEN(0).
            state_next     = S_ALLRED;
            post_walk_next = 1'b1;
          end else begin
            state_next   = S_GREEN;
            cur_dir_next = 2'd0;
          end
        end
      end
      S_EMERG: begin
        if (!bus.emerg_req || edir != cur_dir_reg) state_next = S_YELLOW;
      end
      default: begin
        state_next   = S_GREEN;
        cur_dir_next = 2'd0;
      end
    endcase

    if (state_next != state_reg || state_reg == S_EMERG)
      timer_next = '0;
    else if (timer_reg == TIMER_MAX)
      timer_next = timer_reg;
    else
      timer_next = timer_reg + 1'b1;
  end

  // Outputs are decoded from the upcoming state so the registered copy matches the state.
  always_comb begin
    walk_next         = (state_next == S_WALK) || (state_next == S_WALK_CLR);
    buzzer_next       = (state_next == S_WALK_CLR);
    emerg_active_next = (state_next == S_EMERG);
  end

  for (genvar gi = 0; gi < N_DIR; gi++) begin : g_light
    assign light_next[2*gi +: 2] =
      (cur_dir_next != 2'(gi))                             ? LT_RED    :
      (state_next == S_GREEN || state_next == S_EMERG)     ? LT_GREEN  :
      (state_next == S_YELLOW)                             ? LT_YELLOW : LT_RED;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg        <= S_GREEN;
      cur_dir_reg      <= 2'd0;
      timer_reg        <= '0;
      post_walk_reg    <= 1'b0;
      light_reg        <= LIGHT_RST;
      walk_reg         <= 1'b0;
      buzzer_reg       <= 1'b0;
      emerg_active_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      cur_dir_reg      <= cur_dir_next;
      timer_reg        <= timer_next;
      post_walk_reg    <= post_walk_next;
      light_reg        <= light_next;
      walk_reg         <= walk_next;
      buzzer_reg       <= buzzer_next;
      emerg_active_reg <= emerg_active_next;
    end
  end

  assign bus.light        = light_reg;
  assign bus.walk         = walk_reg;
  assign bus.buzzer       = buzzer_reg;
  assign bus.cur_dir      = cur_dir_reg;
  assign bus.emerg_active = emerg_active_reg;

endmodule

// File: tb/tb_traffic_light_ctrl_n.sv
// Directed bench for traffic_light_ctrl_n with a 2-direction, short-timer configuration.
// Observed word: {emerg_active, buzzer, walk, light[3:2], light[1:0]}.
module tb_traffic_light_ctrl_n;

  logic clk = 1'b0;
  logic reset;
  int   tests_run    = 0;
  int   tests_failed = 0;

  always #5 clk = ~clk;

  traffic_light_ctrl_n_if #(.N_DIR(2)) bus ();

  traffic_light_ctrl_n #(
    .N_DIR(2), .T_GREEN(4), .T_YELLOW(2), .T_ALLRED(1),
    .T_WALK(3), .T_CLR(2), .TW(7)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // dir1 code in [3:2], dir0 code in [1:0]
  localparam logic [6:0] GR   = 7'b000_1000;
  localparam logic [6:0] YR   = 7'b000_1001;
  localparam logic [6:0] RR   = 7'b000_1010;
  localparam logic [6:0] RG   = 7'b000_0010;
  localparam logic [6:0] RY   = 7'b000_0110;
  localparam logic [6:0] WLK  = 7'b001_1010;
  localparam logic [6:0] WCLR = 7'b011_1010;
  localparam logic [6:0] E_GR = 7'b100_1000;
  localparam logic [6:0] E_RG = 7'b100_0010;

  function automatic logic [6:0] obs();
    return {bus.emerg_active, bus.buzzer, bus.walk, bus.light};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Check the currently visible cycle, then advance; repeated n times.
  task automatic expect_run(input string tag, input logic [6:0] val, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s[%0d]", tag, i), 32'(obs()), 32'(val));
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    bus.emerg_req = 1'b0;
    bus.emerg_dir = 2'd0;
    bus.ped_req   = 1'b0;
    step();
    step();

    // Normal cycle with no requests
    do_reset();
    check("rst_cur_dir", 32'(bus.cur_dir), 32'd0);
    expect_run("n_gr", GR, 4);
    expect_run("n_yr", YR, 2);
    expect_run("n_rr0", RR, 1);
    check("n_cur_dir1", 32'(bus.cur_dir), 32'd1);
    expect_run("n_rg", RG, 4);
    expect_run("n_ry", RY, 2);
    expect_run("n_rr1", RR, 1);
`ifdef TLC_PED_REQ_EN
    // No request latched: walk skipped
    expect_run("p_skip_gr", GR, 2);
    bus.ped_req = 1'b1;
    step();
    bus.ped_req = 1'b0;
    expect_run("p_gr", GR, 1);
    expect_run("p_yr", YR, 2);
    expect_run("p_rr0", RR, 1);
    expect_run("p_rg", RG, 4);
    expect_run("p_ry", RY, 2);
    expect_run("p_rr1", RR, 1);
    expect_run("p_walk", WLK, 3);
    expect_run("p_wclr", WCLR, 2);
    expect_run("p_gr2", GR, 4);
    expect_run("p_yr2", YR, 2);
    expect_run("p_rr2", RR, 1);
    expect_run("p_rg2", RG, 4);
    expect_run("p_ry2", RY, 2);
    expect_run("p_rr3", RR, 1);
    expect_run("p_noskip", GR, 1);
`else
    expect_run("n_walk", WLK, 3);
    expect_run("n_wclr", WCLR, 2);
    check("n_walk_cur_dir", 32'(bus.cur_dir), 32'd0);
    expect_run("n_gr2", GR, 4);
    expect_run("n_yr2", YR, 1);

    // Preemption to direction 1 raised in cycle 2 of GREEN(0)
    do_reset();
    expect_run("e1_gr", GR, 1);
    bus.emerg_req = 1'b1;
    bus.emerg_dir = 2'd1;
    expect_run("e1_gr_c2", GR, 1);
    expect_run("e1_yr", YR, 2);
    expect_run("e1_rr", RR, 1);
    check("e1_cur_dir", 32'(bus.cur_dir), 32'd1);
    expect_run("e1_emerg", E_RG, 4);
    bus.emerg_req = 1'b0;
    expect_run("e1_emerg_last", E_RG, 1);
    expect_run("e1_ry", RY, 2);
    expect_run("e1_rr2", RR, 1);
    expect_run("e1_walk", WLK, 1);

    // Preemption of the green direction itself; out-of-range dir aliases to 0
    do_reset();
    bus.emerg_req = 1'b1;
    bus.emerg_dir = 2'd0;
    expect_run("e0_gr", GR, 1);
    expect_run("e0_emerg", E_GR, 2);
    bus.emerg_dir = 2'd3;
    expect_run("e0_alias", E_GR, 2);
    bus.emerg_dir = 2'd1;
    expect_run("e0_sw_emerg", E_GR, 1);
    expect_run("e0_sw_yr", YR, 2);
    expect_run("e0_sw_rr", RR, 1);
    expect_run("e0_sw_rg", E_RG, 1);
    bus.emerg_req = 1'b0;
    expect_run("e0_rel", E_RG, 1);
    expect_run("e0_ry", RY, 2);

    // Preemption arriving during WALK
    do_reset();
    expect_run("w_gr", GR, 4);
    expect_run("w_yr", YR, 2);
    expect_run("w_rr0", RR, 1);
    expect_run("w_rg", RG, 4);
    expect_run("w_ry", RY, 2);
    expect_run("w_rr1", RR, 1);
    expect_run("w_walk", WLK, 1);
    bus.emerg_req = 1'b1;
    bus.emerg_dir = 2'd0;
    expect_run("w_walk2", WLK, 1);
    expect_run("w_wclr", WCLR, 2);
    expect_run("w_rr", RR, 1);
    expect_run("w_emerg", E_GR, 2);

    // Reset mid-EMERG with the request still asserted
    reset = 1'b1;
    step();
    check("r_obs", 32'(obs()), 32'(GR));
    check("r_cur_dir", 32'(bus.cur_dir), 32'd0);
    step();
    check("r_hold", 32'(obs()), 32'(GR));
    bus.emerg_req = 1'b0;
    reset = 1'b0;
    expect_run("r_gr", GR, 4);
    expect_run("r_yr", YR, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/traffic_light_ctrl_n.md
TRAFFIC_LIGHT_CTRL_N -- requirements
Module: traffic_light_ctrl_n

Interface
REQ-001 Parameter N_DIR, default 2, number of approach directions served in round-robin; legal range 2..4.
REQ-002 Parameter T_GREEN, default 30, green duration in clk cycles.
REQ-003 Parameter T_YELLOW, default 5, yellow duration in clk cycles.
REQ-004 Parameter T_ALLRED, default 2, all-red clearance duration in clk cycles.
REQ-005 Parameter T_WALK, default 55, pedestrian walk duration in clk cycles.
REQ-006 Parameter T_CLR, default 5, pedestrian clearance (buzzer) duration in clk cycles; every T_* SHALL be >= 1 and < 2**TW.
REQ-007 Parameter TW, default 7, timer width in bits.
REQ-008 Port clk, input, 1, single clock; all state changes on its rising edge.
REQ-009 Port reset, input, 1, reset; one clock; reset is synchronous and active-high.
REQ-010 Port emerg_req, input, 1, emergency preemption request, level-sensitive.
REQ-011 Port emerg_dir, input, 2, direction to be given green during preemption; values >= N_DIR are treated as 0.
REQ-012 Port ped_req, input, 1, pedestrian button pulse (only used when TLC_PED_REQ_EN is defined).
REQ-013 Port light, output, 2*N_DIR, per-direction light code at [2d+1:2d]: 00 green, 01 yellow, 10 red; 11 never driven.
REQ-014 Port walk, output, 1, pedestrian walk indication for all crossings.
REQ-015 Port buzzer, output, 1, pedestrian clearance warning.
REQ-016 Port cur_dir, output, 2, direction currently owning green/yellow, or last served in ALLRED/WALK.
REQ-017 Port emerg_active, output, 1, high while in state EMERG.

Function
REQ-018 States: GREEN, YELLOW, ALLRED, WALK, WALK_CLR, EMERG; all outputs SHALL be registered.
REQ-019 Each timed state SHALL last exactly its T_* cycles; the timer is cleared on every state entry.
REQ-020 Normal sequence per direction d: GREEN(d) -> YELLOW(d) -> ALLRED; after ALLRED, cur_dir increments (d+1), or WALK if d == N_DIR-1.
REQ-021 WALK -> WALK_CLR -> GREEN(0); walk=1 in WALK and WALK_CLR; buzzer=1 only in WALK_CLR.
REQ-022 In GREEN(d)/YELLOW(d) only direction d is non-red; in ALLRED, WALK, WALK_CLR all directions SHALL be red.
REQ-023 At most one direction non-red in any cycle, including during preemption.
REQ-024 Preemption, emerg_req sampled high: in GREEN(d) with d == emerg_dir -> enter EMERG next cycle (no yellow); in GREEN(d) otherwise -> YELLOW(d) immediately, full T_YELLOW, then ALLRED, then EMERG.
REQ-025 Preemption from YELLOW: finish yellow, then ALLRED -> EMERG; from ALLRED: finish ALLRED -> EMERG; from WALK/WALK_CLR: abort to WALK_CLR if in WALK, finish WALK_CLR, then ALLRED -> EMERG.
REQ-026 EMERG: light[emerg_dir]=green, others red, untimed, held while emerg_req=1; emerg_dir changes during EMERG take effect via YELLOW -> ALLRED -> EMERG of the new direction.
REQ-027 On emerg_req deassert in EMERG: YELLOW(emerg_dir) -> ALLRED -> normal sequence continuing after emerg_dir (same rule as REQ-020).
REQ-028 Timer SHALL saturate, never wrap; EMERG does not use the timer.

Reset
REQ-029 reset=1 at a clk edge SHALL force state GREEN, cur_dir=0, timer=0, light: dir 0 green, all others red, walk=0, buzzer=0, emerg_active=0, ped latch cleared.
REQ-030 reset SHALL override emerg_req and ped_req in the same cycle, including mid-EMERG or mid-WALK.

Configuration
REQ-031 Macro TLC_PED_REQ_EN defined: ped_req pulses latch a request (cleared on WALK entry); after ALLRED of direction N_DIR-1, WALK is entered only if the latch is set, else GREEN(0) directly.
REQ-032 Macro TLC_PED_REQ_EN undefined: ped_req ignored; WALK served every cycle of the round-robin.

Verification
REQ-033 N_DIR=2, T_GREEN=4, T_YELLOW=2, T_ALLRED=1, T_WALK=3, T_CLR=2, no requests -> light sequence G/R x4, Y/R x2, R/R x1, R/G x4, R/Y x2, R/R x1, walk x3, walk+buzzer x2, repeat.
REQ-034 emerg_req=1, emerg_dir=1 during cycle 2 of GREEN(0) -> Y/R x2, R/R x1, R/G with emerg_active=1 until release; release -> R/Y x2, R/R x1, then WALK.
REQ-035 emerg_req=1, emerg_dir=0 during GREEN(0) -> EMERG next cycle, light stays G/R, no yellow.
REQ-036 emerg_req during WALK -> WALK_CLR full 2 cycles with buzzer=1, ALLRED, then EMERG.
REQ-037 reset asserted mid-EMERG with emerg_req still high -> next cycle GREEN(0) outputs, emerg_active=0.
REQ-038 TLC_PED_REQ_EN defined, no ped_req -> WALK skipped; single ped_req pulse during GREEN(0) -> exactly one WALK served.
